// File: rtl/enc_pkg.sv
// Shared constants and types for the handshaked priority encoder.
package enc_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } outState_t;

endpackage

// File: rtl/prio_search.sv
// Combinational circular search: first set bit of vector at or after index start.
module prio_search #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vector,
    input  logic [W-1:0] start,
    output logic [W-1:0] index,
    output logic         found
);

    logic [2*N-1:0] doubled;
    logic [2*N-1:0] shifted;
    logic [N-1:0]   rotated;
    logic [W-1:0]   offset;
    logic [W:0]     sum;

    // Doubling the vector makes the rotate correct for any N, not just powers of two.
    assign doubled = {vector, vector};
    assign shifted = doubled >> start;
    assign rotated = shifted[N-1:0];

    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                found  = 1'b1;
                offset = W'(i);
            end
        end
    end

    always_comb begin
        sum   = {1'b0, offset} + {1'b0, start};
        index = sum[W-1:0];
        if (sum >= (W+1)'(N)) begin
            index = W'(sum - (W+1)'(N));
        end
    end

endmodule

// File: rtl/prio_encoder_hs.sv
// N-bit priority encoder with a registered, valid/ready-handshaked result stage.
module prio_encoder_hs
    import enc_pkg::*;
#(
    parameter int N    = 8,
    parameter int MODE = MODE_FIXED,
    localparam int W   = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] dataIn,
    input  logic         inValid,
    output logic         inReady,
    output logic [W-1:0] codeOut,
    output logic         multiHit,
    output logic         zeroIn,
    output logic         outValid,
    input  logic         outReady
);

    outState_t    state;
    logic [W-1:0] ptr;
    logic [W-1:0] start;
    logic [W-1:0] winner;
    logic [W-1:0] nextPtr;
    logic [N-1:0] lowCleared;
    logic         found;
    logic         multi;
    logic         capture;

    assign start   = (MODE == MODE_RR) ? ptr : '0;
    assign inReady = (state == EMPTY) || outReady;
    assign capture = inValid && inReady;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign lowCleared = dataIn & (dataIn - N'(1));
    assign multi      = |lowCleared;
    assign nextPtr    = (winner == W'(N - 1)) ? '0 : winner + W'(1);

    prio_search #(.N(N)) search (
        .vector (dataIn),
        .start  (start),
        .index  (winner),
        .found  (found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            codeOut  <= '0;
            multiHit <= 1'b0;
            zeroIn   <= 1'b0;
            ptr      <= '0;
        end else begin
            if (capture) begin
                state    <= FULL;
                codeOut  <= found ? winner : '0;
                multiHit <= multi;
                zeroIn   <= !found;
                if (MODE == MODE_RR && found) begin
                    ptr <= nextPtr;
                end
            end else if (outReady) begin
                state <= EMPTY;
            end
        end
    end

    assign outValid = (state == FULL);

endmodule

// File: tb/tb_prio_encoder_hs.sv
// Scoreboard bench: fixed N=8, round-robin N=8 and round-robin N=5 instances.
module tb_prio_encoder_hs;
    import enc_pkg::*;

    typedef struct {
        logic [2:0] code;
        logic       multi;
        logic       zero;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] din0, din1;
    logic [4:0] din2;
    logic [2:0] vin;
    logic [2:0] rdy;
    logic [2:0] inRdy;
    logic [2:0] code0, code1, code2;
    logic       multi0, multi1, multi2;
    logic       zero0, zero1, zero2;
    logic       outValid0, outValid1, outValid2;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   tests = 0;
    int   fails = 0;

    prio_encoder_hs #(.N(8), .MODE(MODE_FIXED)) dut0 (
        .clk(clk), .rst_n(rst_n), .dataIn(din0), .inValid(vin[0]), .inReady(inRdy[0]),
        .codeOut(code0), .multiHit(multi0), .zeroIn(zero0), .outValid(outValid0), .outReady(rdy[0])
    );

    prio_encoder_hs #(.N(8), .MODE(MODE_RR)) dut1 (
        .clk(clk), .rst_n(rst_n), .dataIn(din1), .inValid(vin[1]), .inReady(inRdy[1]),
        .codeOut(code1), .multiHit(multi1), .zeroIn(zero1), .outValid(outValid1), .outReady(rdy[1])
    );

    prio_encoder_hs #(.N(5), .MODE(MODE_RR)) dut2 (
        .clk(clk), .rst_n(rst_n), .dataIn(din2), .inValid(vin[2]), .inReady(inRdy[2]),
        .codeOut(code2), .multiHit(multi2), .zeroIn(zero2), .outValid(outValid2), .outReady(rdy[2])
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic scoreCheck(input int which, input logic [2:0] code, input logic m, input logic z);
        exp_t e;
        int   depth;
        depth = (which == 0) ? q0.size() : (which == 1) ? q1.size() : q2.size();
        if (depth == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected result on dut%0d: code %0d", which, code);
        end else begin
            case (which)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            checkOutput($sformatf("dut%0d code", which), 32'(code), 32'(e.code));
            checkOutput($sformatf("dut%0d multiHit", which), 32'(m), 32'(e.multi));
            checkOutput($sformatf("dut%0d zeroIn", which), 32'(z), 32'(e.zero));
        end
    endtask

    // Monitor: a result is consumed at the next rising edge when valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n) begin
            if (outValid0 && rdy[0]) scoreCheck(0, code0, multi0, zero0);
            if (outValid1 && rdy[1]) scoreCheck(1, code1, multi1, zero1);
            if (outValid2 && rdy[2]) scoreCheck(2, code2, multi2, zero2);
        end
    end

    // Called just after a rising edge; returns just after the capturing edge.
    task automatic applyStimulus(input int which, input logic [7:0] d, input logic [2:0] code,
                                 input logic m, input logic z);
        exp_t e;
        bit   done;
        e.code  = code;
        e.multi = m;
        e.zero  = z;
        done    = 0;
        case (which)
            0:       din0 = d;
            1:       din1 = d;
            default: din2 = d[4:0];
        endcase
        vin[which] = 1'b1;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            if (inRdy[which]) begin
                case (which)
                    0:       q0.push_back(e);
                    1:       q1.push_back(e);
                    default: q2.push_back(e);
                endcase
                done = 1;
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("[TB] FAIL capture timeout on dut%0d: inReady 0, required 1", which);
        end
        @(posedge clk);
        #1;
        vin[which] = 1'b0;
    endtask

    initial begin
        clk   = 1'b0;
        rst_n = 1'b0;
        vin   = '0;
        rdy   = 3'b111;
        din0  = '0;
        din1  = '0;
        din2  = '0;

        #3;
        checkOutput("reset outValid0", 32'(outValid0), 0);
        checkOutput("reset outValid1", 32'(outValid1), 0);
        checkOutput("reset outValid2", 32'(outValid2), 0);
        checkOutput("reset code0", 32'(code0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fixed priority: one-hot sweep, multi-hit and zero vectors.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 8'(1 << i), 3'(i), 1'b0, 1'b0);
        end
        applyStimulus(0, 8'b10010100, 3'd2, 1'b1, 1'b0);
        applyStimulus(0, 8'b00000000, 3'd0, 1'b0, 1'b1);

        // Backpressure: result must hold while stalled, then swap with no bubble.
        @(posedge clk);
        #1;
        rdy[0] = 1'b0;
        applyStimulus(0, 8'b00001000, 3'd3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stall inReady", 32'(inRdy[0]), 0);
            checkOutput("stall code", 32'(code0), 3);
            checkOutput("stall outValid", 32'(outValid0), 1);
        end
        @(posedge clk);
        #1;
        rdy[0] = 1'b1;
        applyStimulus(0, 8'b01000000, 3'd6, 1'b0, 1'b0);
        checkOutput("swap outValid", 32'(outValid0), 1);

        // Round-robin: park a result with ptr = 5, then reset asynchronously.
        rdy[1] = 1'b0;
        applyStimulus(1, 8'b00010000, 3'd4, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("pre-reset outValid1", 32'(outValid1), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("async reset outValid1", 32'(outValid1), 0);
        checkOutput("async reset code1", 32'(code1), 0);
        checkOutput("async reset multi1", 32'(multi1), 0);
        checkOutput("async reset zero1", 32'(zero1), 0);
        q0.delete();
        q1.delete();
        q2.delete();
        @(negedge clk);
        rst_n  = 1'b1;
        rdy[1] = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1, 8'b10010100, 3'd2, 1'b1, 1'b0);
        applyStimulus(1, 8'b10010100, 3'd4, 1'b1, 1'b0);
        applyStimulus(1, 8'b10010100, 3'd7, 1'b1, 1'b0);
        applyStimulus(1, 8'b10010100, 3'd2, 1'b1, 1'b0);
        applyStimulus(1, 8'b00000000, 3'd0, 1'b0, 1'b1);
        applyStimulus(1, 8'b10010100, 3'd4, 1'b1, 1'b0);

        // Round-robin with non-power-of-two width.
        applyStimulus(2, 8'b00010001, 3'd0, 1'b1, 1'b0);
        checkOutput("n5 ptr range", 32'(dut2.ptr <= 3'd4), 1);
        applyStimulus(2, 8'b00010001, 3'd4, 1'b1, 1'b0);
        checkOutput("n5 ptr range", 32'(dut2.ptr <= 3'd4), 1);
        applyStimulus(2, 8'b00010001, 3'd0, 1'b1, 1'b0);
        checkOutput("n5 ptr range", 32'(dut2.ptr <= 3'd4), 1);
        applyStimulus(2, 8'b00010001, 3'd4, 1'b1, 1'b0);
        checkOutput("n5 ptr range", 32'(dut2.ptr <= 3'd4), 1);

        repeat (4) @(posedge clk);
        #1;
        checkOutput("drain q0", 32'(q0.size()), 0);
        checkOutput("drain q1", 32'(q1.size()), 0);
        checkOutput("drain q2", 32'(q2.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prio_encoder_hs.md
Name: prio_encoder_hs

Overview:
- Parametrised successor of the team's 8-to-3 combinational encoder: encodes an N-bit request vector to a ceil(log2 N)-bit index.
- Adds a registered output stage with valid/ready handshakes on both sides.
- Adds fixed-priority and round-robin modes, plus multi-hit and zero-input flags.
- Sits between request sources (interrupt lines, arbiter requests) and a downstream consumer that may stall.

Parameters:
- N, 8, request vector width; any value >= 2, power of two not required.
- W, $clog2(N), code width; localparam derived from N, not overridable.
- MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dataIn  in  N  request vector.
- inValid  in  1  dataIn is valid this cycle.
- inReady  out  1  block can accept dataIn this cycle.
- codeOut  out  W  encoded index of the winning request.
- multiHit  out  1  more than one bit of the captured vector was set.
- zeroIn  out  1  captured vector was all zeros.
- outValid  out  1  codeOut/multiHit/zeroIn hold a result.
- outReady  in  1  downstream accepts the result this cycle.

Behaviour:
- Reset, asynchronous while rst_n = 0: outValid = 0, codeOut = 0, multiHit = 0, zeroIn = 0, rr pointer ptr = 0.
- Output register states:
  - EMPTY (outValid = 0) and FULL (outValid = 1).
  - inReady = !outValid || outReady, combinational.
- Capture: when inValid && inReady, the result is registered at that edge, so outValid rises the next cycle (latency 1).
- Transitions:
  - EMPTY -> FULL on capture.
  - FULL -> EMPTY on outReady without capture.
  - FULL -> FULL with new data when outReady and capture occur in the same cycle (no bubble; full throughput).
  - FULL with outReady = 0: all outputs held stable; inReady = 0.
- Fixed mode: codeOut = lowest set index of dataIn.
- Round-robin mode:
  - The search starts at index ptr and wraps N-1 -> 0; the first set bit wins.
  - On a capture with a nonzero vector, ptr <= (winner + 1) mod N, with wrap to 0 when winner = N-1.
  - ptr stays in 0..N-1 for non-power-of-two N.
- Zero vector is still accepted: zeroIn = 1, codeOut = 0, multiHit = 0, ptr unchanged.
- multiHit = 1 iff popcount(dataIn) >= 2 at capture; mode-independent.
- inValid while inReady = 0: no capture. The source must hold its data; the block does not store it.
- Reset mid-transfer: a pending result is discarded, no partial output, and ptr returns to 0.
- dataIn is sampled only on the capture edge; changes at other times have no effect.

Decomposition:
- Package enc_pkg holds MODE_FIXED = 0 and MODE_RR = 1.
- One combinational sub-module, prio_search:
  - Inputs: vector [N], start [W].
  - Outputs: index [W], found.
  - Implemented as a rotate, lowest-set-bit search, and un-rotate.
  - Fixed mode ties start to 0.
- The top level contains only the handshake, output register, ptr and flags.

Test Plan:
- Reset: assert rst_n = 0 while outValid = 1 and ptr = 5 -> outValid/codeOut/flags go to 0 immediately, without a clock; the first RR search afterwards starts at index 0.
- Fixed, N = 8, one-hot sweep 8'b00000001..8'b10000000 with outReady = 1 -> codeOut = 0..7, one cycle after each capture; multiHit = 0, zeroIn = 0.
- Fixed, dataIn = 8'b10010100 -> codeOut = 2, multiHit = 1; with dataIn = 8'b00000000 -> zeroIn = 1, codeOut = 0.
- RR, dataIn = 8'b10010100 held for four transfers -> codeOut sequence 2, 4, 7, 2 (ptr 3, 5, 0, 3).
- Backpressure: capture 8'b00001000, then outReady = 0 for 3 cycles -> inReady = 0, codeOut = 3 stable. Then outReady = 1 with inValid = 1, dataIn = 8'b01000000 in the same cycle -> codeOut = 6 on the next cycle, outValid never drops.
- N = 5, RR mode, dataIn = 5'b10001 repeated -> codes 0, 4, 0, 4; ptr never exceeds 4.
